// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes, functs,
// ALU and mux codes, plus the per-state Moore output table.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11,
        S_ERROR    = 4'd15
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // fetch/pcWrite/branch are raw terms; MemReady and Zero gating happens at the top.
    typedef struct packed {
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       regDst;
        logic       memtoReg;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [2:0] aluControl;
        logic [1:0] pcSrc;
        logic       fetch;
        logic       pcWrite;
        logic       branch;
        logic       fault;
    } ctrl_t;

    function automatic ctrl_t stateOutputs(input state_t s, input logic [2:0] decodedAlu);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH:    begin c.memRead = 1'b1; c.aluSrcB = SRCB_FOUR; c.aluControl = ALU_ADD;
                              c.pcSrc = PC_ALU; c.fetch = 1'b1; end
            S_DECODE:   begin c.aluSrcB = SRCB_IMMSH; c.aluControl = ALU_ADD; end
            S_MEMADR:   begin c.aluSrcA = 1'b1; c.aluSrcB = SRCB_IMM; c.aluControl = ALU_ADD; end
            S_MEMREAD:  begin c.iorD = 1'b1; c.memRead = 1'b1; end
            S_MEMWB:    begin c.memtoReg = 1'b1; c.regWrite = 1'b1; end
            S_MEMWRITE: begin c.iorD = 1'b1; c.memWrite = 1'b1; end
            S_EXECUTE:  begin c.aluSrcA = 1'b1; c.aluSrcB = SRCB_B; c.aluControl = decodedAlu; end
            S_ALUWB:    begin c.regDst = 1'b1; c.regWrite = 1'b1; end
            S_BRANCH:   begin c.aluSrcA = 1'b1; c.aluSrcB = SRCB_B; c.aluControl = decodedAlu;
                              c.pcSrc = PC_ALUOUT; c.branch = 1'b1; end
            S_ADDIEX:   begin c.aluSrcA = 1'b1; c.aluSrcB = SRCB_IMM; c.aluControl = ALU_ADD; end
            S_ADDIWB:   c.regWrite = 1'b1;
            S_JUMP:     begin c.pcSrc = PC_JUMP; c.pcWrite = 1'b1; end
            S_ERROR:    c.fault = 1'b1;
            default:    c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle: instruction fields and flags in, selects and strobes out.
interface mips_multicycle_ctrl_if #(parameter int RETIRE_W = 32);
    // Memory handshake: a request (MemRead/MemWrite) stays asserted and stable until the
    // memory raises MemReady; the access completes, and a write commits, in that cycle only.
    logic [5:0]          Op;
    logic [5:0]          Funct;
    logic                Zero;
    logic                MemReady;
    logic                IorD;
    logic                MemRead;
    logic                MemWrite;
    logic                IRWrite;
    logic                RegDst;
    logic                MemtoReg;
    logic                RegWrite;
    logic                ALUSrcA;
    logic [1:0]          ALUSrcB;
    logic [2:0]          ALUControl;
    logic [1:0]          PCSrc;
    logic                PCEn;
    logic [3:0]          State;
    logic [RETIRE_W-1:0] Retired;
    logic                Fault;

    modport master (
        input  Op, Funct, Zero, MemReady,
        output IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCEn, State, Retired, Fault
    );

    modport slave (
        output Op, Funct, Zero, MemReady,
        input  IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCEn, State, Retired, Fault
    );
endinterface

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
// ALUOp + Funct to ALUControl; functLegal tells DECODE whether an R-type can execute.
module mips_alu_decoder
    import mips_mc_pkg::*;
(
    input  logic [1:0] aluOp,
    input  logic [5:0] funct,
    output logic [2:0] aluControl,
    output logic       functLegal
);
    logic [2:0] functAlu;

    always_comb begin
        functLegal = 1'b1;
        functAlu   = ALU_ADD;
        case (funct)
            FN_ADD:  functAlu = ALU_ADD;
            FN_SUB:  functAlu = ALU_SUB;
            FN_AND:  functAlu = ALU_AND;
            FN_OR:   functAlu = ALU_OR;
            FN_SLT:  functAlu = ALU_SLT;
            default: functLegal = 1'b0;
        endcase

        case (aluOp)
            ALUOP_ADD:   aluControl = ALU_ADD;
            ALUOP_SUB:   aluControl = ALU_SUB;
            ALUOP_FUNCT: aluControl = functAlu;
            default:     aluControl = ALU_ADD;
        endcase
    end
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM with memory wait states, timeout fault and retire counter.
module mips_multicycle_ctrl
    import mips_mc_pkg::*;
#(
    parameter int WAIT_MAX = 15,
    parameter int RETIRE_W = 32
) (
    input  logic CLK,
    input  logic Reset,
    mips_multicycle_ctrl_if.master bus
);
    localparam int CW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

    state_t              state;
    state_t              nxt;
    ctrl_t               ctrlQ;
    logic [5:0]          opQ;
    logic [CW-1:0]       waitCnt;
    logic [RETIRE_W-1:0] retiredQ;
    logic [1:0]          aluOp;
    logic [2:0]          aluCtl;
    logic                functLegal;
    logic                memState;
    logic                timeout;
    logic                fetchGo;

    // ALUOp comes from the opcode seen in DECODE, so EXECUTE/BRANCH selects are registered on entry.
    always_comb begin
        aluOp = ALUOP_ADD;
        if (bus.Op == OP_RTYPE)    aluOp = ALUOP_FUNCT;
        else if (bus.Op == OP_BEQ) aluOp = ALUOP_SUB;
    end

    mips_alu_decoder u_aluDec (
        .aluOp      (aluOp),
        .funct      (bus.Funct),
        .aluControl (aluCtl),
        .functLegal (functLegal)
    );

    assign memState = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
    assign timeout  = (WAIT_MAX != 0) && memState && !bus.MemReady &&
                      (waitCnt == CW'(WAIT_MAX - 1));

    always_comb begin
        nxt = state;
        case (state)
            S_FETCH:    if (bus.MemReady) nxt = S_DECODE;
            S_DECODE: begin
                case (bus.Op)
                    OP_LW, OP_SW: nxt = S_MEMADR;
                    OP_RTYPE:     nxt = functLegal ? S_EXECUTE : S_ERROR;
                    OP_BEQ:       nxt = S_BRANCH;
                    OP_ADDI:      nxt = S_ADDIEX;
                    OP_J:         nxt = S_JUMP;
                    default:      nxt = S_ERROR;
                endcase
            end
            S_MEMADR:   nxt = (opQ == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (bus.MemReady) nxt = S_MEMWB;
            S_MEMWRITE: if (bus.MemReady) nxt = S_FETCH;
            S_EXECUTE:  nxt = S_ALUWB;
            S_ADDIEX:   nxt = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: nxt = S_FETCH;
            default:    nxt = S_ERROR;
        endcase
        if (timeout) nxt = S_ERROR;
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state    <= S_FETCH;
            ctrlQ    <= stateOutputs(S_FETCH, ALU_ADD);
            opQ      <= '0;
            waitCnt  <= '0;
            retiredQ <= '0;
        end else begin
            state <= nxt;
            ctrlQ <= stateOutputs(nxt, aluCtl);
            if (state == S_DECODE) opQ <= bus.Op;
            if (nxt != state)                  waitCnt <= '0;
            else if (memState && !bus.MemReady) waitCnt <= waitCnt + 1'b1;
            // Every entry into FETCH from another state marks a completed instruction.
            if (nxt == S_FETCH && state != S_FETCH) retiredQ <= retiredQ + 1'b1;
        end
    end

    assign fetchGo        = ctrlQ.fetch & bus.MemReady;
    assign bus.IorD       = ctrlQ.iorD;
    assign bus.MemRead    = ctrlQ.memRead & ~Reset;
    assign bus.MemWrite   = ctrlQ.memWrite & ~Reset;
    assign bus.IRWrite    = fetchGo & ~Reset;
    assign bus.RegDst     = ctrlQ.regDst;
    assign bus.MemtoReg   = ctrlQ.memtoReg;
    assign bus.RegWrite   = ctrlQ.regWrite & ~Reset;
    assign bus.ALUSrcA    = ctrlQ.aluSrcA;
    assign bus.ALUSrcB    = ctrlQ.aluSrcB;
    assign bus.ALUControl = ctrlQ.aluControl;
    assign bus.PCSrc      = ctrlQ.pcSrc;
    assign bus.PCEn       = (fetchGo | ctrlQ.pcWrite | (ctrlQ.branch & bus.Zero)) & ~Reset;
    assign bus.State      = state;
    assign bus.Retired    = retiredQ;
    assign bus.Fault      = ctrlQ.fault;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: instruction-level reference model feeding a per-cycle scoreboard.
module tb_mips_multicycle_ctrl;
    localparam int WAIT_MAX = 4;
    localparam int RETIRE_W = 4;
    localparam int W = 4 + 17 + RETIRE_W;

    localparam logic [3:0] FE = 4'd0, DE = 4'd1, MA = 4'd2, MR = 4'd3, MWB = 4'd4, MW = 4'd5;
    localparam logic [3:0] EX = 4'd6, AWB = 4'd7, BR = 4'd8, AX = 4'd9, AXW = 4'd10, JP = 4'd11;
    localparam logic [3:0] ER = 4'd15;

    logic CLK = 1'b0;
    logic Reset = 1'b1;

    mips_multicycle_ctrl_if #(.RETIRE_W(RETIRE_W)) bus ();

    mips_multicycle_ctrl #(.WAIT_MAX(WAIT_MAX), .RETIRE_W(RETIRE_W)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    // clock / reset
    always #5 CLK = ~CLK;

    logic [W-1:0]        exp_q[$];
    logic [W-1:0]        got_v;
    logic [W-1:0]        want_v;
    int                  total = 0;
    int                  bad = 0;
    logic [RETIRE_W-1:0] retired_m = '0;
    logic [5:0]          legal_fn[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    function automatic logic [5:0] rnd6();
        return 6'($urandom_range(0, 63));
    endfunction

    // 0 lw, 1 sw, 2 legal R, 3 illegal R, 4 beq, 5 addi, 6 j, 7 illegal op
    function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'b100011: return 0;
            6'b101011: return 1;
            6'b000000: return (fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100 ||
                               fn == 6'b100101 || fn == 6'b101010) ? 2 : 3;
            6'b000100: return 4;
            6'b001000: return 5;
            6'b000010: return 6;
            default:   return 7;
        endcase
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] fn);
        case (fn)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b000;
        endcase
    endfunction

    // {IorD,MemRead,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUControl,PCSrc,PCEn,Fault}
    function automatic logic [16:0] exp_outs(input logic [3:0] st, input logic mr, input logic z,
                                             input logic [5:0] fv);
        logic iord, mrd, mwr, irw, rdst, m2r, rw, sa, pcen, flt;
        logic [1:0] sb, ps;
        logic [2:0] ac;
        {iord, mrd, mwr, irw, rdst, m2r, rw, sa, pcen, flt} = '0;
        sb = 2'b00; ps = 2'b00; ac = 3'b000;
        case (st)
            FE:  begin mrd = 1; sb = 2'b01; ac = 3'b010; irw = mr; pcen = mr; end
            DE:  begin sb = 2'b11; ac = 3'b010; end
            MA:  begin sa = 1; sb = 2'b10; ac = 3'b010; end
            MR:  begin iord = 1; mrd = 1; end
            MWB: begin m2r = 1; rw = 1; end
            MW:  begin iord = 1; mwr = 1; end
            EX:  begin sa = 1; ac = alu_of(fv); end
            AWB: begin rdst = 1; rw = 1; end
            BR:  begin sa = 1; ac = 3'b110; ps = 2'b01; pcen = z; end
            AX:  begin sa = 1; sb = 2'b10; ac = 3'b010; end
            AXW: rw = 1;
            JP:  begin ps = 2'b10; pcen = 1; end
            ER:  flt = 1;
            default: ;
        endcase
        return {iord, mrd, mwr, irw, rdst, m2r, rw, sa, sb, ac, ps, pcen, flt};
    endfunction

    function automatic logic [W-1:0] exp_reset();
        logic [16:0] o;
        o = {8'b0, 2'b01, 3'b010, 2'b00, 1'b0, 1'b0};
        return {FE, o, {RETIRE_W{1'b0}}};
    endfunction

    // driver tasks
    task automatic cyc(input logic [3:0] st, input logic mr, input logic z,
                       input logic [5:0] opv, input logic [5:0] fv);
        @(posedge CLK); #1;
        Reset = 1'b0; bus.MemReady = mr; bus.Zero = z; bus.Op = opv; bus.Funct = fv;
        exp_q.push_back({st, exp_outs(st, mr, z, fv), retired_m});
    endtask

    task automatic rst_cyc(input int n);
        repeat (n) begin
            @(posedge CLK); #1;
            Reset = 1'b1; bus.MemReady = 1'($urandom_range(0, 1)); bus.Zero = 1'($urandom_range(0, 1));
            retired_m = '0;
            exp_q.push_back(exp_reset());
        end
    endtask

    task automatic err_hold(input int n);
        repeat (n) cyc(ER, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd6(), rnd6());
        rst_cyc(2);
    endtask

    task automatic mem_phase(input logic [3:0] st, input int w, input logic rnd_op,
                             input logic [5:0] opv, input logic [5:0] fv, output bit dead);
        dead = 0;
        if (w >= WAIT_MAX) begin
            repeat (WAIT_MAX) cyc(st, 1'b0, 1'b0, rnd_op ? rnd6() : opv, fv);
            dead = 1;
        end else begin
            repeat (w) cyc(st, 1'b0, 1'b0, rnd_op ? rnd6() : opv, fv);
            cyc(st, 1'b1, 1'b0, rnd_op ? rnd6() : opv, fv);
        end
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int wf,
                             input int wm, input logic z);
        bit dead;
        bit done;
        int k;
        k = kind_of(op, fn);
        done = 0;
        mem_phase(FE, wf, 1'b0, op, fn, dead);
        if (dead) err_hold(3);
        else begin
            cyc(DE, 1'($urandom_range(0, 1)), z, op, fn);
            case (k)
                0: begin
                    cyc(MA, 1'($urandom_range(0, 1)), z, rnd6(), fn);
                    mem_phase(MR, wm, 1'b1, op, fn, dead);
                    if (dead) err_hold(3);
                    else begin cyc(MWB, 1'($urandom_range(0, 1)), z, rnd6(), fn); done = 1; end
                end
                1: begin
                    cyc(MA, 1'($urandom_range(0, 1)), z, rnd6(), fn);
                    mem_phase(MW, wm, 1'b1, op, fn, dead);
                    if (dead) err_hold(3);
                    else done = 1;
                end
                2: begin
                    cyc(EX, 1'($urandom_range(0, 1)), z, op, fn);
                    cyc(AWB, 1'($urandom_range(0, 1)), z, op, fn);
                    done = 1;
                end
                4: begin cyc(BR, 1'($urandom_range(0, 1)), z, op, fn); done = 1; end
                5: begin
                    cyc(AX, 1'($urandom_range(0, 1)), z, op, fn);
                    cyc(AXW, 1'($urandom_range(0, 1)), z, op, fn);
                    done = 1;
                end
                6: begin cyc(JP, 1'($urandom_range(0, 1)), z, op, fn); done = 1; end
                default: err_hold(20);
            endcase
        end
        if (done) retired_m = retired_m + 1'b1;
    endtask

    // scoreboard monitor
    always @(negedge CLK) begin
        if (exp_q.size() != 0) begin
            want_v = exp_q.pop_front();
            got_v  = {bus.State, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite, bus.RegDst,
                      bus.MemtoReg, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl,
                      bus.PCSrc, bus.PCEn, bus.Fault, bus.Retired};
            total++;
            if (got_v !== want_v) begin
                bad++;
                $display("FAIL cycle_check t=%0t {state,outs,retired}: got %h want %h",
                         $time, got_v, want_v);
            end
        end
    end

    initial begin
        bit dead;
        int k;
        int wf;
        int wm;
        logic [5:0] op;
        logic [5:0] fn;
        bus.Op = '0; bus.Funct = '0; bus.Zero = 1'b0; bus.MemReady = 1'b0;
        rst_cyc(3);

        run_instr(6'b100011, rnd6(), 0, 0, 1'b0);        // lw, no waits
        run_instr(6'b001000, rnd6(), 3, 0, 1'b0);        // addi with 3 fetch waits
        run_instr(6'b000100, rnd6(), 0, 0, 1'b1);        // beq taken
        run_instr(6'b000100, rnd6(), 0, 0, 1'b0);        // beq not taken
        run_instr(6'b000000, 6'b101010, 0, 0, 1'b0);     // slt
        run_instr(6'b000000, 6'b000000, 0, 0, 1'b0);     // illegal funct -> error, reset
        run_instr(6'b101011, rnd6(), 0, 1, 1'b0);        // sw one wait
        run_instr(6'b101011, rnd6(), 0, 6, 1'b0);        // sw timeout

        // asynchronous reset in the middle of a MEMREAD wait
        run_instr(6'b000010, rnd6(), 0, 0, 1'b0);
        mem_phase(FE, 0, 1'b0, 6'b100011, 6'd0, dead);
        cyc(DE, 1'b1, 1'b0, 6'b100011, 6'd0);
        cyc(MA, 1'b1, 1'b0, rnd6(), 6'd0);
        cyc(MR, 1'b0, 1'b0, rnd6(), 6'd0);
        cyc(MR, 1'b0, 1'b0, rnd6(), 6'd0);
        @(posedge CLK); #1;
        bus.MemReady = 1'b0;
        #1;
        Reset = 1'b1;
        retired_m = '0;
        exp_q.push_back(exp_reset());
        rst_cyc(1);
        run_instr(6'b100011, rnd6(), 0, 0, 1'b0);

        // retire-counter wrap
        repeat (18) run_instr(6'b000010, rnd6(), $urandom_range(0, 2), 0, 1'b0);

        // randomized instruction mix
        repeat (80) begin
            k  = $urandom_range(0, 9);
            wf = ($urandom_range(0, 9) == 0) ? 4 : $urandom_range(0, 3);
            wm = ($urandom_range(0, 9) == 0) ? 5 : $urandom_range(0, 3);
            fn = rnd6();
            case (k)
                0, 8: op = 6'b100011;
                1, 9: op = 6'b101011;
                2, 3: begin
                    op = 6'b000000;
                    if ($urandom_range(0, 4) != 0) fn = legal_fn[$urandom_range(0, 4)];
                end
                4: op = 6'b000100;
                5: op = 6'b001000;
                6: op = 6'b000010;
                default: begin
                    op = rnd6();
                    while (kind_of(op, 6'b100000) != 7) op = rnd6();
                end
            endcase
            run_instr(op, fn, wf, wm, 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge CLK);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: left %0d want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
